// File: rtl/fft_stage_ctrl_if.sv
// Handshake bundle between an FFT stage controller and its butterfly datapath.
// master = controller side (drives burst outputs), slave = datapath/observer side.
interface fft_stage_ctrl_if #(
    parameter int AW = 5
);
    logic          shift_valid;
    logic          bfly_valid;
    logic [AW-1:0] twd_addr;
    logic          frame_done;
    logic          busy;
    logic          ovf_err;

    modport master (
        input  shift_valid,
        output bfly_valid,
        output twd_addr,
        output frame_done,
        output busy,
        output ovf_err
    );

    modport slave (
        output shift_valid,
        input  bfly_valid,
        input  twd_addr,
        input  frame_done,
        input  busy,
        input  ovf_err
    );
endinterface

// File: rtl/fft_stage_ctrl.sv
// FFT stage burst controller: start-edge detect, delay, twiddle-address burst, done pulse.
// Define FFT_STAGE_CTRL_PEND_EN to queue one start arriving while a frame is in flight.
module fft_stage_ctrl #(
    parameter int PULSE_CYCLES = 32,
    parameter int DELAY_CYCLES = 2,
    parameter int AW           = $clog2(PULSE_CYCLES)
) (
    input  logic              clk,
    input  logic              rstn,
    fft_stage_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0] ADDR_LAST = AW'(PULSE_CYCLES - 1);
    localparam logic [3:0]    DLY_LOAD  = (DELAY_CYCLES > 0) ? 4'(DELAY_CYCLES - 1) : 4'd0;

    state_t        state_reg, state_next;
    logic [3:0]    dly_reg, dly_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic          ovf_reg, ovf_next;
    logic          prev_reg;
    logic          bfly_reg;
    logic          done_reg;
    logic          busy_reg;
    logic          start;
    logic          launch;
`ifdef FFT_STAGE_CTRL_PEND_EN
    logic          pend_reg, pend_next;
`endif

    // prev_reg resets high so a level already present at reset release is not an edge
    assign start = bus.shift_valid & ~prev_reg;

    always_comb begin
        state_next = state_reg;
        dly_next   = dly_reg;
        addr_next  = addr_reg;
        ovf_next   = ovf_reg;
        launch     = 1'b0;
`ifdef FFT_STAGE_CTRL_PEND_EN
        pend_next  = pend_reg;
`endif

        case (state_reg)
            IDLE: begin
                launch = start;
            end
            WAIT: begin
                if (dly_reg == 4'd0) begin
                    state_next = RUN;
                end else begin
                    dly_next = dly_reg - 4'd1;
                end
            end
            RUN: begin
                if (addr_reg == ADDR_LAST) begin
                    state_next = DONE;
                end else begin
                    addr_next = addr_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
`ifdef FFT_STAGE_CTRL_PEND_EN
                // A start coinciding with DONE re-arms the slot the queued start just vacated
                launch    = pend_reg | start;
                pend_next = pend_reg & start;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (launch) begin
            if (DELAY_CYCLES > 0) begin
                state_next = WAIT;
                dly_next   = DLY_LOAD;
            end else begin
                state_next = RUN;
            end
        end

`ifdef FFT_STAGE_CTRL_PEND_EN
        if (start && (state_reg == WAIT || state_reg == RUN)) begin
            if (pend_reg) begin
                ovf_next = 1'b1;
            end else begin
                pend_next = 1'b1;
            end
        end
`else
        if (start && state_reg != IDLE) begin
            ovf_next = 1'b1;
        end
`endif

        if (state_next != RUN) begin
            addr_next = '0;
        end
    end

    // Outputs are registered from next-state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            dly_reg   <= 4'd0;
            addr_reg  <= '0;
            ovf_reg   <= 1'b0;
            prev_reg  <= 1'b1;
            bfly_reg  <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
`ifdef FFT_STAGE_CTRL_PEND_EN
            pend_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            dly_reg   <= dly_next;
            addr_reg  <= addr_next;
            ovf_reg   <= ovf_next;
            prev_reg  <= bus.shift_valid;
            bfly_reg  <= (state_next == RUN);
            done_reg  <= (state_next == DONE);
            busy_reg  <= (state_next != IDLE);
`ifdef FFT_STAGE_CTRL_PEND_EN
            pend_reg  <= pend_next;
`endif
        end
    end

    assign bus.bfly_valid = bfly_reg;
    assign bus.twd_addr   = addr_reg;
    assign bus.frame_done = done_reg;
    assign bus.busy       = busy_reg;
    assign bus.ovf_err    = ovf_reg;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: segment table for the main bursts plus
// hand-written reset-abort and multi-start sequences; DUTs with DELAY 2 and DELAY 0.
module tb_fft_stage_ctrl;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic sv = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fft_stage_ctrl_if #(.AW(AW)) if2 ();
    fft_stage_ctrl_if #(.AW(AW)) if0 ();

    assign if2.shift_valid = sv;
    assign if0.shift_valid = sv;

    fft_stage_ctrl #(.PULSE_CYCLES(32), .DELAY_CYCLES(2), .AW(AW)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if2)
    );

    fft_stage_ctrl #(.PULSE_CYCLES(32), .DELAY_CYCLES(0), .AW(AW)) u_dut0 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if0)
    );

    // One record covers a run of cycles with constant input and expected outputs;
    // base >= 0 means twd_addr is expected to equal (cycle - base).
    typedef struct {
        int   first;
        int   last;
        logic sv;
        logic dut0;
        logic bfly;
        int   base;
        logic done;
        logic busy;
        logic ovf;
    } seg_t;

    seg_t tbl[$];

    function automatic seg_t mk(input int first, input int last, input logic s, input logic d0,
                                input logic bfly, input int base, input logic done,
                                input logic busy, input logic ovf);
        seg_t r;
        r.first = first; r.last = last; r.sv = s; r.dut0 = d0;
        r.bfly = bfly; r.base = base; r.done = done; r.busy = busy; r.ovf = ovf;
        return r;
    endfunction

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        sv   = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_bfly",  -1, {31'd0, if2.bfly_valid}, 32'd0);
        chk("rst_addr",  -1, {27'd0, if2.twd_addr},   32'd0);
        chk("rst_done",  -1, {31'd0, if2.frame_done}, 32'd0);
        chk("rst_busy",  -1, {31'd0, if2.busy},       32'd0);
        chk("rst_ovf",   -1, {31'd0, if2.ovf_err},    32'd0);
        chk("rst_ovf0",  -1, {31'd0, if0.ovf_err},    32'd0);
        chk("rst_busy0", -1, {31'd0, if0.busy},       32'd0);
        tick();
        rstn = 1'b1;
    endtask

    task automatic run_segs(input int lo, input int hi);
        logic       o_bfly, o_done, o_busy, o_ovf;
        logic [4:0] o_addr;
        int         exp_addr;
        int         nf0;
        for (int i = lo; i <= hi; i++) begin
            nf0 = n_fail;
            for (int c = tbl[i].first; c <= tbl[i].last; c++) begin
                sv = tbl[i].sv;
                @(negedge clk);
                if (tbl[i].dut0) begin
                    o_bfly = if0.bfly_valid; o_addr = if0.twd_addr; o_done = if0.frame_done;
                    o_busy = if0.busy; o_ovf = if0.ovf_err;
                end else begin
                    o_bfly = if2.bfly_valid; o_addr = if2.twd_addr; o_done = if2.frame_done;
                    o_busy = if2.busy; o_ovf = if2.ovf_err;
                end
                exp_addr = (tbl[i].base >= 0) ? (c - tbl[i].base) : 0;
                chk("bfly_valid", c, {31'd0, o_bfly}, {31'd0, tbl[i].bfly});
                chk("twd_addr",   c, {27'd0, o_addr}, exp_addr);
                chk("frame_done", c, {31'd0, o_done}, {31'd0, tbl[i].done});
                chk("busy",       c, {31'd0, o_busy}, {31'd0, tbl[i].busy});
                chk("ovf_err",    c, {31'd0, o_ovf},  {31'd0, tbl[i].ovf});
                tick();
            end
            $display("segment %0d cycles %0d..%0d dut_delay%0d new_errors=%0d",
                     i, tbl[i].first, tbl[i].last, tbl[i].dut0 ? 0 : 2, n_fail - nf0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_lo, a_hi, b_lo, b_hi;
        int n_done, n_bursts;
        logic last_bfly;

        // Scenario A: rise 10, fall 20, rise 30 on the DELAY=2 instance
        a_lo = tbl.size();
        tbl.push_back(mk( 0,  9, 0, 0, 0, -1, 0, 0, 0));
        tbl.push_back(mk(10, 10, 1, 0, 0, -1, 0, 0, 0));
        tbl.push_back(mk(11, 12, 1, 0, 0, -1, 0, 1, 0));
        tbl.push_back(mk(13, 19, 1, 0, 1, 13, 0, 1, 0));
        tbl.push_back(mk(20, 29, 0, 0, 1, 13, 0, 1, 0));
        tbl.push_back(mk(30, 30, 1, 0, 1, 13, 0, 1, 0));
`ifdef FFT_STAGE_CTRL_PEND_EN
        tbl.push_back(mk(31, 44, 1, 0, 1, 13, 0, 1, 0));
        tbl.push_back(mk(45, 45, 1, 0, 0, -1, 1, 1, 0));
        tbl.push_back(mk(46, 47, 1, 0, 0, -1, 0, 1, 0));
        tbl.push_back(mk(48, 79, 1, 0, 1, 48, 0, 1, 0));
        tbl.push_back(mk(80, 80, 1, 0, 0, -1, 1, 1, 0));
        tbl.push_back(mk(81, 89, 1, 0, 0, -1, 0, 0, 0));
`else
        tbl.push_back(mk(31, 44, 1, 0, 1, 13, 0, 1, 1));
        tbl.push_back(mk(45, 45, 1, 0, 0, -1, 1, 1, 1));
        tbl.push_back(mk(46, 89, 1, 0, 0, -1, 0, 0, 1));
`endif
        a_hi = tbl.size() - 1;

        // Scenario B: DELAY=0 instance, rise at 5
        b_lo = tbl.size();
        tbl.push_back(mk( 0,  4, 0, 1, 0, -1, 0, 0, 0));
        tbl.push_back(mk( 5,  5, 1, 1, 0, -1, 0, 0, 0));
        tbl.push_back(mk( 6, 37, 1, 1, 1,  6, 0, 1, 0));
        tbl.push_back(mk(38, 38, 1, 1, 0, -1, 1, 1, 0));
        tbl.push_back(mk(39, 45, 1, 1, 0, -1, 0, 0, 0));
        b_hi = tbl.size() - 1;

        do_reset();
        run_segs(a_lo, a_hi);

        do_reset();
        run_segs(b_lo, b_hi);

        // Reset in the middle of a burst, shift_valid held high through release
        do_reset();
        for (int c = 0; c <= 70; c++) begin
            sv   = (c >= 10);
            rstn = (c != 20);
            @(negedge clk);
            if (c == 19) begin
                chk("abort_pre_bfly", c, {31'd0, if2.bfly_valid}, 32'd1);
                chk("abort_pre_addr", c, {27'd0, if2.twd_addr},   32'd6);
            end
            if (c >= 21) begin
                chk("abort_bfly", c, {31'd0, if2.bfly_valid}, 32'd0);
                chk("abort_addr", c, {27'd0, if2.twd_addr},   32'd0);
                chk("abort_done", c, {31'd0, if2.frame_done}, 32'd0);
                chk("abort_busy", c, {31'd0, if2.busy},       32'd0);
            end
            tick();
        end
        rstn = 1'b1;
        $display("sequence reset_abort done errors_so_far=%0d", n_fail);

        // Three extra start events inside one burst
        do_reset();
        n_done    = 0;
        n_bursts  = 0;
        last_bfly = 1'b0;
        for (int c = 0; c <= 119; c++) begin
            sv = (c == 10 || c == 11 || c == 15 || c == 16 ||
                  c == 20 || c == 21 || c == 25 || c == 26);
            @(negedge clk);
            if (if2.frame_done) n_done++;
            if (if2.bfly_valid && !last_bfly) n_bursts++;
            last_bfly = if2.bfly_valid;
`ifdef FFT_STAGE_CTRL_PEND_EN
            if (c == 20)  chk("multi_ovf_before", c, {31'd0, if2.ovf_err}, 32'd0);
            if (c == 21)  chk("multi_ovf_after",  c, {31'd0, if2.ovf_err}, 32'd1);
            if (c == 47)  chk("multi_gap_bfly",   c, {31'd0, if2.bfly_valid}, 32'd0);
            if (c == 48)  chk("multi_b2_bfly",    c, {31'd0, if2.bfly_valid}, 32'd1);
`else
            if (c == 15)  chk("multi_ovf_before", c, {31'd0, if2.ovf_err}, 32'd0);
            if (c == 16)  chk("multi_ovf_after",  c, {31'd0, if2.ovf_err}, 32'd1);
            if (c == 48)  chk("multi_no_b2",      c, {31'd0, if2.bfly_valid}, 32'd0);
`endif
            tick();
        end
        chk("multi_ovf_end", 119, {31'd0, if2.ovf_err}, 32'd1);
`ifdef FFT_STAGE_CTRL_PEND_EN
        chk("multi_done_count",  119, n_done,   32'd2);
        chk("multi_burst_count", 119, n_bursts, 32'd2);
`else
        chk("multi_done_count",  119, n_done,   32'd1);
        chk("multi_burst_count", 119, n_bursts, 32'd1);
`endif
        $display("sequence multi_start bursts=%0d done_pulses=%0d", n_bursts, n_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stage_ctrl.md
FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 Parameter PULSE_CYCLES, default 32: length in cycles of one butterfly burst; legal range 2..256.
REQ-002 Parameter DELAY_CYCLES, default 2: cycles from start detection to first bfly_valid; legal range 0..15.
REQ-003 Parameter AW, default $clog2(PULSE_CYCLES): width of twd_addr.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rstn  input  1  synchronous, active-low reset.
REQ-006 shift_valid  input  1  frame-ready level from the previous FFT stage.
REQ-007 bfly_valid  output  1  butterfly enable; high for exactly one burst per accepted frame.
REQ-008 twd_addr  output  AW  twiddle ROM address (burst cycle index).
REQ-009 frame_done  output  1  one-cycle pulse after each completed burst.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 ovf_err  output  1  sticky flag: a start event was lost.

Function
REQ-012 Start event: shift_valid high on a cycle where its registered previous value is low; the previous-value register resets to 1, so a level held through reset release is not a start.
REQ-013 FSM states: IDLE, WAIT, RUN, DONE; encoding is free.
REQ-014 IDLE->WAIT on start event when DELAY_CYCLES>0; IDLE->RUN directly when DELAY_CYCLES==0.
REQ-015 WAIT: down-counter loaded with DELAY_CYCLES-1; WAIT->RUN when counter reaches 0, giving first bfly_valid exactly DELAY_CYCLES+1 cycles after the start cycle.
REQ-016 RUN: bfly_valid=1; twd_addr increments 0..PULSE_CYCLES-1, one per cycle; RUN->DONE after the cycle with twd_addr==PULSE_CYCLES-1.
REQ-017 twd_addr is 0 whenever bfly_valid is 0.
REQ-018 DONE: frame_done=1 for one cycle; next state is WAIT/RUN (per REQ-014) if a start is pending, else IDLE.
REQ-019 Start event while in WAIT, RUN or DONE: handled per Configuration (REQ-025/026).
REQ-020 Start event and a pending start coexisting (second lost start): ovf_err set; pending remains single.
REQ-021 All outputs registered; no combinational path from shift_valid to any output.

Reset
REQ-022 rstn low at a rising edge: state=IDLE, bfly_valid=0, twd_addr=0, frame_done=0, busy=0, ovf_err=0, pending flag=0, counters=0, previous-value register=1.
REQ-023 Reset mid-burst aborts immediately; no frame_done is produced for the aborted frame.
REQ-024 ovf_err clears only by reset.

Configuration
REQ-025 With FFT_STAGE_CTRL_PEND_EN defined: one-deep pending-start register; a start during WAIT/RUN/DONE sets it; DONE consumes it, so the next burst begins back-to-back (DONE->RUN when DELAY_CYCLES==0); ovf_err only on a start while pending is already set.
REQ-026 Without FFT_STAGE_CTRL_PEND_EN: no pending register; any start outside IDLE is dropped and sets ovf_err; DONE always returns to IDLE.

Verification (DELAY_CYCLES=2, PULSE_CYCLES=32 unless stated)
REQ-027 Reset release, then shift_valid rises at cycle 10 -> bfly_valid high cycles 13..44, twd_addr 0..31, frame_done at 45, busy 11..45.
REQ-028 DELAY_CYCLES=0, shift_valid rises at cycle 5 -> bfly_valid high cycles 6..37, frame_done at 38.
REQ-029 PEND_EN defined: rises at 10, falls at 20, rises at 30 -> first burst 13..44, DONE at 45, second burst 48..79, frame_done at 80, ovf_err stays 0.
REQ-030 PEND_EN undefined: same stimulus as REQ-029 -> only one burst 13..44, ovf_err=1 from cycle 31 onward.
REQ-031 rstn low at cycle 20 during a burst -> bfly_valid=0 and twd_addr=0 from cycle 21, no frame_done; shift_valid held high through release -> no new burst.
REQ-032 PEND_EN defined: three start events during one burst -> ovf_err=1 after the second event, exactly two bursts produced.
